// File: rtl/serdes_pkg.sv
// Shared definitions for the SERDES clocking and deserializer tree.
package serdes_pkg;

    localparam int unsigned SERDES_MAX_STAGES = 8;

    typedef logic [SERDES_MAX_STAGES-1:0] divclk_t;

    // Fast cycles per deserialized word for a divider with the given stage count.
    function automatic int unsigned word_len(input int unsigned stages);
        return 32'd1 << stages;
    endfunction

endpackage

// File: rtl/clkdiv_bit.sv
// One divider stage: toggle flop with ripple carry and synchronous clear.
module clkdiv_bit (
    input  logic clk_i,
    input  logic clr_i,
    input  logic carry_i,
    output logic carry_o,
    output logic q_o
);

    logic q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 1'b0;
        end else if (carry_i) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk_i) begin
        q_q <= q_d;
    end

    // Output comes straight from the flop so every divided clock is glitch-free.
    assign q_o     = q_q;
    assign carry_o = carry_i & q_q;

endmodule

// File: rtl/clkdiv_chain.sv
// Binary clock divider chain: clkout[k] = clkin / 2^(k+1), all bits registered on clkin.
// Optional word_strobe output enabled by defining CLKDIV_WORD_STROBE_EN.
`ifndef SERDES_STAGES
`define SERDES_STAGES 4
`endif

module clkdiv_chain
    import serdes_pkg::*;
#(
    parameter int unsigned STAGES = `SERDES_STAGES - 1
) (
    input  logic              clkin,
    input  logic              rst,
`ifdef CLKDIV_WORD_STROBE_EN
    output logic              word_strobe,
`endif
    output logic [STAGES-1:0] clkout
);

    if (STAGES < 1 || STAGES > SERDES_MAX_STAGES) begin : g_bad_stages
        $error("clkdiv_chain: STAGES out of range");
    end

    // carry[k] = &cnt[k-1:0]; bit k toggles only when all lower bits wrap to 0.
    logic [STAGES:0] carry;
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_bit
        clkdiv_bit u_bit (
            .clk_i   (clkin),
            .clr_i   (rst),
            .carry_i (carry[k]),
            .carry_o (carry[k+1]),
            .q_o     (clkout[k])
        );
    end

    logic unused_carry;
    assign unused_carry = carry[STAGES];

`ifdef CLKDIV_WORD_STROBE_EN
    // Count value one edge before the terminal count, so the strobe flop is high while cnt is max.
    localparam logic [STAGES-1:0] StrobePre = STAGES'(word_len(STAGES) - 2);

    logic word_strobe_q;

    always_ff @(posedge clkin) begin
        if (rst) begin
            word_strobe_q <= 1'b0;
        end else begin
            word_strobe_q <= (clkout == StrobePre);
        end
    end

    assign word_strobe = word_strobe_q;
`endif

endmodule

// File: tb/tb_clkdiv_chain.sv
// Self-checking bench for clkdiv_chain at STAGES=2 and STAGES=3 with a queued scoreboard.
module tb_clkdiv_chain;

    logic       clk;
    logic       rst2, rst3;
    logic [1:0] clkout2;
    logic [2:0] clkout3;
`ifdef CLKDIV_WORD_STROBE_EN
    logic       ws2, ws3;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [1:0] m2 = '0;
    logic [2:0] m3 = '0;
    logic [1:0] exp2_q[$];
    logic [2:0] exp3_q[$];
`ifdef CLKDIV_WORD_STROBE_EN
    logic       expws_q[$];
`endif

    clkdiv_chain #(.STAGES(2)) u_dut2 (
        .clkin       (clk),
        .rst         (rst2),
`ifdef CLKDIV_WORD_STROBE_EN
        .word_strobe (ws2),
`endif
        .clkout      (clkout2)
    );

    clkdiv_chain #(.STAGES(3)) u_dut3 (
        .clkin       (clk),
        .rst         (rst3),
`ifdef CLKDIV_WORD_STROBE_EN
        .word_strobe (ws3),
`endif
        .clkout      (clkout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive reset values, advance the models, then compare DUT outputs after the edge.
    task automatic cycle(input logic r2, input logic r3);
        logic [1:0] e2;
        logic [2:0] e3;
        @(negedge clk);
        rst2 = r2;
        rst3 = r3;
        m2 = r2 ? 2'd0 : m2 + 2'd1;
        m3 = r3 ? 3'd0 : m3 + 3'd1;
        exp2_q.push_back(m2);
        exp3_q.push_back(m3);
`ifdef CLKDIV_WORD_STROBE_EN
        expws_q.push_back(!r2 && (m2 == 2'd3));
`endif
        @(posedge clk);
        #1;
        e2 = exp2_q.pop_front();
        e3 = exp3_q.pop_front();
        check_eq("sb_clkout2", clkout2, e2);
        check_eq("sb_clkout3", clkout3, e3);
`ifdef CLKDIV_WORD_STROBE_EN
        check_eq("sb_word_strobe2", ws2, expws_q.pop_front());
`endif
    endtask

    initial begin
        logic [1:0]  seq2 [5];
        logic [2:0]  prev3;
        int unsigned highs [3];
        int unsigned rises2;
        int unsigned n;

        seq2[0] = 2'd1; seq2[1] = 2'd2; seq2[2] = 2'd3; seq2[3] = 2'd0; seq2[4] = 2'd1;
        rst2 = 1'b1;
        rst3 = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1);
            check_eq("rst_clkout2", clkout2, 0);
            check_eq("rst_clkout3", clkout3, 0);
`ifdef CLKDIV_WORD_STROBE_EN
            check_eq("rst_word_strobe2", ws2, 0);
`endif
        end

        // Release: clkout2 must step 01,10,11,00,01.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            check_eq("seq2", clkout2, seq2[i]);
        end

        // 64 free-running cycles on STAGES=3: duty and edge alignment.
        for (int k = 0; k < 3; k++) highs[k] = 0;
        rises2 = 0;
        prev3  = clkout3;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 1'b0);
            for (int k = 0; k < 3; k++) if (clkout3[k]) highs[k]++;
            check_eq("toggle_bit0", clkout3[0], !prev3[0]);
            if (!prev3[2] && clkout3[2]) begin
                rises2++;
                check_eq("align_low_after", clkout3[1:0], 0);
                check_eq("align_low_before", prev3[1:0], 3);
            end
            prev3 = clkout3;
        end
        check_eq("duty_bit0", highs[0], 32);
        check_eq("duty_bit1", highs[1], 32);
        check_eq("duty_bit2", highs[2], 32);
        check_eq("rises_bit2", rises2, 8);

        // Mid-run reset when the count is 5.
        for (int i = 0; i < 16 && m3 != 3'd5; i++) cycle(1'b0, 1'b0);
        check_eq("pre_rst_cnt5", clkout3, 5);
        cycle(1'b0, 1'b1);
        check_eq("mid_rst_zero", clkout3, 0);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0);
            n++;
            if (clkout3[2]) break;
        end
        check_eq("first_rise_bit2", n, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
